// File: rtl/song_rom_arbiter.sv
// rtl/song_rom_arbiter.sv - shares the song note ROM read port between playback and preview
//
// Playback has priority over preview. A streak counter bounds how many
// consecutive playback grants can pass while preview waits. Each grant pushes
// a {valid, id} tag into a ROM_LATENCY+1 deep shift pipeline. When the tag
// reaches the end of the pipeline, the returned byte is registered into the
// issuing requester's data output.
//
// Ports:
//   clk_in, rst_in            - clock, synchronous active-low reset
//   play_req/addr/gnt         - playback request, address, combinational grant
//   play_valid/data           - playback one-cycle data pulse, registered byte
//   prev_req/addr/gnt         - preview request, address, combinational grant
//   prev_valid/data           - preview one-cycle data pulse, registered byte
//   rom_addr, rom_data        - ROM read port (registered address, read data)
//   busy                      - any request pending or any read in flight

module song_rom_arbiter #(
    parameter int ADDR_BITS   = 10,
    parameter int DATA_BITS   = 8,
    parameter int ROM_LATENCY = 1,
    parameter int MAX_STREAK  = 4
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 play_req,
    input  logic [ADDR_BITS-1:0] play_addr,
    output logic                 play_gnt,
    output logic                 play_valid,
    output logic [DATA_BITS-1:0] play_data,
    input  logic                 prev_req,
    input  logic [ADDR_BITS-1:0] prev_addr,
    output logic                 prev_gnt,
    output logic                 prev_valid,
    output logic [DATA_BITS-1:0] prev_data,
    output logic [ADDR_BITS-1:0] rom_addr,
    input  logic [DATA_BITS-1:0] rom_data,
    output logic                 busy
);

    // Stage k holds a tag during cycle N+1+k for a grant in cycle N, so the
    // last stage lines up with rom_data being valid.
    localparam int         DEPTH      = ROM_LATENCY + 1;
    localparam logic [3:0] STREAK_MAX = 4'(MAX_STREAK);

    logic [3:0]       streak;
    logic [DEPTH-1:0] tag_v;
    logic [DEPTH-1:0] tag_id;   // 1 = preview, 0 = playback
    logic             ret_play;
    logic             ret_prev;

    // Grants are gated by rst_in so nothing is accepted while in reset.
    always_comb begin
        play_gnt = rst_in && play_req && (!prev_req || (streak < STREAK_MAX));
        prev_gnt = rst_in && prev_req && !play_gnt;
    end

    assign ret_play = tag_v[DEPTH-1] && !tag_id[DEPTH-1];
    assign ret_prev = tag_v[DEPTH-1] &&  tag_id[DEPTH-1];
    assign busy     = play_req || prev_req || (|tag_v) || play_valid || prev_valid;

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            streak     <= '0;
            tag_v      <= '0;
            tag_id     <= '0;
            rom_addr   <= '0;
            play_valid <= 1'b0;
            prev_valid <= 1'b0;
            play_data  <= '0;
            prev_data  <= '0;
        end else begin
            // Streak counts playback wins only while preview is actually waiting.
            if (prev_gnt || !prev_req) begin
                streak <= '0;
            end else if (play_gnt && (streak != STREAK_MAX)) begin
                streak <= streak + 4'd1;
            end

            if (play_gnt) begin
                rom_addr <= play_addr;
            end else if (prev_gnt) begin
                rom_addr <= prev_addr;
            end

            tag_v  <= {tag_v[DEPTH-2:0],  play_gnt || prev_gnt};
            tag_id <= {tag_id[DEPTH-2:0], prev_gnt};

            play_valid <= ret_play;
            prev_valid <= ret_prev;
            if (ret_play) begin
                play_data <= rom_data;
            end
            if (ret_prev) begin
                prev_data <= rom_data;
            end
        end
    end

endmodule
